// File: rtl/computer_ctrl_pkg.sv
// Shared types for the run/step/halt sequencer of the 16-bit computer:
// controller states, halt causes, host command opcodes and the halt priority.
package computer_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RSTH   = 3'd1,
    ST_RUN    = 3'd2,
    ST_STEP   = 3'd3,
    ST_HALTED = 3'd4
  } ctrl_state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE    = 3'd0,
    CAUSE_STOP    = 3'd1,
    CAUSE_BREAK   = 3'd2,
    CAUSE_HALTOP  = 3'd3,
    CAUSE_DONE    = 3'd4,
    CAUSE_TIMEOUT = 3'd5,
    CAUSE_STEP    = 3'd6
  } halt_cause_t;

  localparam logic [1:0] CMD_START  = 2'd0;
  localparam logic [1:0] CMD_STEP   = 2'd1;
  localparam logic [1:0] CMD_STOP   = 2'd2;
  localparam logic [1:0] CMD_RESUME = 2'd3;

  // Resolves simultaneous halt conditions seen in one RUN cycle.
  function automatic halt_cause_t pick_cause(input logic stop_hit,
                                             input logic brk_hit,
                                             input logic hop_hit,
                                             input logic done_hit,
                                             input logic to_hit);
    if (stop_hit)      return CAUSE_STOP;
    else if (brk_hit)  return CAUSE_BREAK;
    else if (hop_hit)  return CAUSE_HALTOP;
    else if (done_hit) return CAUSE_DONE;
    else if (to_hit)   return CAUSE_TIMEOUT;
    else               return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Clearable up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/computer_run_controller.sv
// Run/step/halt sequencer: owns the computer's reset and per-cycle enable,
// counts executed cycles and stops on command, breakpoint, halt opcode, done store or budget.
module computer_run_controller
  import computer_ctrl_pkg::*;
#(
  parameter int             N          = 16,
  parameter int             RST_CYCLES = 2,
  parameter int             CNT_W      = 16,
  parameter logic [N-1:0]   HALT_INSTR = 16'hFFFF,
  parameter logic [N-1:0]   DONE_ADDR  = 16'd84
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  input  logic             bp_en,
  input  logic [N-1:0]     bp_addr,
  input  logic [CNT_W-1:0] max_cycles,
  input  logic [N-1:0]     pc,
  input  logic [N-1:0]     instr,
  input  logic             memwrite,
  input  logic [N-1:0]     dataadr,
  output logic             cpu_reset,
  output logic             cpu_en,
  output logic             halted,
  output logic [2:0]       halt_cause,
  output logic [CNT_W-1:0] cycle_count,
  output logic [2:0]       dbg_state
);

  // Handshake: a command is consumed on a clock edge where cmd_valid && cmd_ready.
  // cmd_ready is high in IDLE, RUN and HALTED; in RUN only STOP has an effect,
  // and commands that make no sense in the current state are consumed and dropped.

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

  ctrl_state_t state_q, state_d;
  halt_cause_t cause_q, cause_d, run_cause;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic resumed_q, resumed_d;
  logic cmd_ready_q, cmd_ready_d;
  logic cpu_reset_q, cpu_reset_d;
  logic halted_q, halted_d;

  logic cmd_acc, cnt_clr, cpu_en_c;
  logic stop_hit, brk_hit, hop_hit, done_hit, to_hit;
  logic [CNT_W-1:0] count;

  assign cmd_acc  = cmd_valid && cmd_ready_q;
  assign stop_hit = cmd_acc && (cmd_op == CMD_STOP);
  // The first RUN cycle after RESUME may sit on the breakpoint and must leave it.
  assign brk_hit  = bp_en && (pc == bp_addr) && !resumed_q;
  assign hop_hit  = (instr == HALT_INSTR);
  assign done_hit = memwrite && (dataadr == DONE_ADDR);
  assign to_hit   = (max_cycles != '0) && (count == (max_cycles - CNT_W'(1)));
  assign run_cause = pick_cause(stop_hit, brk_hit, hop_hit, done_hit, to_hit);

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    rst_cnt_d = rst_cnt_q;
    resumed_d = resumed_q;
    cnt_clr   = 1'b0;
    cpu_en_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_acc && (cmd_op == CMD_START)) begin
          state_d   = ST_RSTH;
          rst_cnt_d = '0;
          cause_d   = CAUSE_NONE;
          cnt_clr   = 1'b1;
        end
      end
      ST_RSTH: begin
        resumed_d = 1'b0;
        if (rst_cnt_q == RST_LAST) begin
          state_d = ST_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end
      ST_RUN: begin
        resumed_d = 1'b0;
        // Breakpoint and halt opcode stop before the instruction executes,
        // unless a STOP in the same cycle wins and lets it complete.
        cpu_en_c = stop_hit || !(brk_hit || hop_hit);
        if (run_cause != CAUSE_NONE) begin
          state_d = ST_HALTED;
          cause_d = run_cause;
        end
      end
      ST_STEP: begin
        cpu_en_c = 1'b1;
        state_d  = ST_HALTED;
        cause_d  = CAUSE_STEP;
      end
      ST_HALTED: begin
        if (cmd_acc) begin
          case (cmd_op)
            CMD_START: begin
              state_d   = ST_RSTH;
              rst_cnt_d = '0;
              cause_d   = CAUSE_NONE;
              cnt_clr   = 1'b1;
            end
            CMD_STEP:   state_d = ST_STEP;
            CMD_RESUME: begin
              state_d   = ST_RUN;
              resumed_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cmd_ready_d = (state_d == ST_IDLE) || (state_d == ST_RUN) || (state_d == ST_HALTED);
    cpu_reset_d = (state_d == ST_IDLE) || (state_d == ST_RSTH);
    halted_d    = (state_d == ST_HALTED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cause_q     <= CAUSE_NONE;
      rst_cnt_q   <= '0;
      resumed_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      cpu_reset_q <= 1'b1;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      rst_cnt_q   <= rst_cnt_d;
      resumed_q   <= resumed_d;
      cmd_ready_q <= cmd_ready_d;
      cpu_reset_q <= cpu_reset_d;
      halted_q    <= halted_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (cnt_clr),
    .en    (cpu_en_c),
    .count (count)
  );

  // cpu_en is decoded from the registered state and the current pc/instr so
  // that a breakpoint or halt opcode can suppress the very cycle it appears in.
  assign cpu_en      = cpu_en_c;
  assign cmd_ready   = cmd_ready_q;
  assign cpu_reset   = cpu_reset_q;
  assign halted      = halted_q;
  assign halt_cause  = cause_q;
  assign cycle_count = count;
  assign dbg_state   = state_q;

endmodule
